// File: rtl/apbDecode_package.sv
// Shared apbDecode types, including the APB initiator command/response bundles.
// Used by apb_initiator and its interface.
package apbDecode_package;

  typedef logic [31:0] apbAddrT;
  typedef logic [31:0] apbDataT;

  localparam int APB_INIT_MAX_WORDS = 3;

  typedef struct packed {
    apbAddrT                          addr;
    logic                             write;
    logic [1:0]                       nwords;
    logic [APB_INIT_MAX_WORDS*32-1:0] wdata;
  } apbInitCmdSt;

  typedef struct packed {
    logic [APB_INIT_MAX_WORDS*32-1:0] rdata;
    logic                             slverr;
    logic                             timeout;
    logic [1:0]                       count;
  } apbInitRspSt;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apbInitStateT;

endpackage

// File: rtl/apb_initiator_if.sv
// Command, response and APB signal bundle for apb_initiator.
// master = initiator view, slave = requester/target view.
interface apb_initiator_if
  import apbDecode_package::*;
#(
  parameter int MAX_WORDS = APB_INIT_MAX_WORDS
) ();

  logic                   cmd_valid;
  logic                   cmd_ready;
  apbAddrT                cmd_addr;
  logic                   cmd_write;
  logic [1:0]             cmd_nwords;
  logic [MAX_WORDS*32-1:0] cmd_wdata;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [MAX_WORDS*32-1:0] rsp_rdata;
  logic                   rsp_slverr;
  logic                   rsp_timeout;
  logic [1:0]             rsp_count;

  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  apbAddrT                paddr;
  apbDataT                pwdata;
  logic                   pready;
  apbDataT                prdata;
  logic                   pslverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write,
    input  cmd_nwords, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr,
    output rsp_timeout, rsp_count,
    input  rsp_ready,
    output psel, penable, pwrite,
    output paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write,
    output cmd_nwords, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr,
    input  rsp_timeout, rsp_count,
    output rsp_ready,
    input  psel, penable, pwrite,
    input  paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_initiator_timeout.sv
// ACCESS-phase wait counter: clear, count while enabled,
// expire on the LIMIT-th enabled cycle.
module apb_initiator_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Count stalled ACCESS cycles since the last clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/apb_initiator.sv
// APB initiator: one command -> up to MAX_WORDS APB transfers -> one response.
// Optional ACCESS timeout when APB_INITIATOR_TIMEOUT_EN is defined.
module apb_initiator
  import apbDecode_package::*;
#(
  parameter int MAX_WORDS = APB_INIT_MAX_WORDS
`ifdef APB_INITIATOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic             clk,
  input logic             rst,
  apb_initiator_if.master bus
);

  apbInitStateT           state_q;
  apbInitStateT           state_d;
  apbInitCmdSt            cmd_q;
  logic [MAX_WORDS*32-1:0] rdata_q;
  logic                   slverr_q;
  logic [1:0]             count_q;
  logic [1:0]             idx;
  logic                   accept;
  logic                   bad_len;
  logic                   last;
  logic                   busy;

  assign accept  = (state_q == IDLE) && !rst && bus.cmd_valid;
  assign bad_len = (bus.cmd_nwords == 2'd0) ||
                   ({30'd0, bus.cmd_nwords} > 32'(MAX_WORDS));
  assign last    = (idx == cmd_q.nwords - 2'd1);
  assign busy    = (state_q == SETUP) || (state_q == ACCESS);

`ifdef APB_INITIATOR_TIMEOUT_EN
  logic expire;
  logic timeout_q;

  apb_initiator_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == SETUP),
    .en     ((state_q == ACCESS) && !bus.pready),
    .expire (expire)
  );

  // Timeout flag: cleared per command, set when ACCESS gives up.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (accept) begin
      timeout_q <= 1'b0;
    end else if (state_q == ACCESS && !bus.pready && expire) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.rsp_timeout = timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/APB control outputs.
  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = !rst;
        if (accept) begin
          state_d = bad_len ? RESP : SETUP;
        end
      end
      SETUP: begin
        bus.psel = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        if (bus.pready) begin
          state_d = (bus.pslverr || last) ? RESP : SETUP;
        end
`ifdef APB_INITIATOR_TIMEOUT_EN
        else if (expire) begin
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, word index and aggregated response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      count_q  <= '0;
      idx      <= '0;
    end else begin
      if (accept) begin
        cmd_q <= '{addr:   bus.cmd_addr,
                   write:  bus.cmd_write,
                   nwords: bus.cmd_nwords,
                   wdata:  bus.cmd_wdata};
        rdata_q  <= '0;
        slverr_q <= bad_len;
        count_q  <= '0;
        idx      <= '0;
      end
      if (state_q == ACCESS) begin
        if (bus.pready) begin
          if (bus.pslverr) begin
            slverr_q <= 1'b1;
          end else begin
            count_q <= count_q + 2'd1;
            if (!cmd_q.write) begin
              rdata_q[{idx, 5'd0} +: 32] <= bus.prdata;
            end
            if (!last) begin
              idx <= idx + 2'd1;
            end
          end
        end
`ifdef APB_INITIATOR_TIMEOUT_EN
        else if (expire) begin
          slverr_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.pwrite = busy && cmd_q.write;
  assign bus.paddr  = busy ? cmd_q.addr + {28'd0, idx, 2'b00} : '0;
  assign bus.pwdata = (busy && cmd_q.write) ?
                      cmd_q.wdata[{idx, 5'd0} +: 32] : '0;

  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_slverr = slverr_q;
  assign bus.rsp_count  = count_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: APB target model plus
// transfer/response scoreboards. Define APB_INITIATOR_TIMEOUT_EN for timeout tests.
module tb_apb_initiator;
  import apbDecode_package::*;

  typedef struct packed {
    logic [95:0] rdata;
    logic        slverr;
    logic        timeout;
    logic [1:0]  count;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wait_n = 0;
  int          err_at = -1;
  bit          never_rdy = 1'b0;
  int          xfer_i = 0;
  int          wcnt = 0;
  int          setups = 0;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_wdata = '0;
  xfer_t       mon_e;
  xfer_t       apb_q[$];
  rsp_t        rsp_q[$];

  apb_initiator_if bus ();

  apb_initiator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a ^ 32'h5A5A_0000) + 32'h1;
  endfunction

  // APB target model and transfer scoreboard.
  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      n_cmp++;
      if (bus.paddr !== hold_addr || bus.pwdata !== hold_wdata) begin
        n_bad++;
        $display("FAIL access_stable: got %h/%h want %h/%h",
                 bus.paddr, bus.pwdata, hold_addr, hold_wdata);
      end
      if (never_rdy || wcnt < wait_n) begin
        bus.pready = 1'b0;
        wcnt++;
      end else begin
        bus.pready  = 1'b1;
        bus.pslverr = (xfer_i == err_at);
        bus.prdata  = rd_fn(bus.paddr);
        n_cmp++;
        if (apb_q.size() == 0) begin
          n_bad++;
          $display("FAIL apb_xfer: unexpected transfer at %h",
                   bus.paddr);
        end else begin
          mon_e = apb_q.pop_front();
          if ({bus.paddr, bus.pwrite, bus.pwdata} !== mon_e) begin
            n_bad++;
            $display("FAIL apb_xfer: got %h/%b/%h want %h/%b/%h",
                     bus.paddr, bus.pwrite, bus.pwdata,
                     mon_e.addr, mon_e.write, mon_e.wdata);
          end
        end
        xfer_i++;
      end
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = '0;
      wcnt        = 0;
      if (bus.psel) begin
        hold_addr  = bus.paddr;
        hold_wdata = bus.pwdata;
        setups++;
      end
    end
  end

  // Push expectations, issue one command, collect its response.
  task automatic run_cmd(
    input  logic [31:0] a,
    input  logic        w,
    input  logic [1:0]  n,
    input  logic [95:0] wd,
    input  int          errw,
    input  int          waitc,
    input  bit          to_exp,
    input  int          hold,
    output int          lat,
    output rsp_t        got,
    output bit          held_ok,
    output bit          rdy_ok
  );
    rsp_t  r;
    xfer_t x;
    int    k;
    int    t0;
    r = '0;
    apb_q.delete();
    if (n == 2'd0) begin
      r.slverr = 1'b1;
    end else if (!to_exp) begin
      for (int i = 0; i < int'(n); i++) begin
        x.addr  = a + 32'(4 * i);
        x.write = w;
        x.wdata = w ? wd[32*i +: 32] : 32'h0;
        apb_q.push_back(x);
        if (i == errw) begin
          r.slverr = 1'b1;
          break;
        end
        r.count = r.count + 2'd1;
        if (!w) r.rdata[32*i +: 32] = rd_fn(x.addr);
      end
    end else begin
      r.slverr  = 1'b1;
      r.timeout = 1'b1;
    end
    rsp_q.push_back(r);
    lat     = -1;
    got     = '0;
    held_ok = 1'b1;
    rdy_ok  = 1'b1;
    wait_n    = waitc;
    err_at    = errw;
    never_rdy = to_exp;
    xfer_i    = 0;
    @(negedge clk);
    bus.rsp_ready  = (hold == 0);
    bus.cmd_addr   = a;
    bus.cmd_write  = w;
    bus.cmd_nwords = n;
    bus.cmd_wdata  = wd;
    bus.cmd_valid  = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    t0 = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.rsp_valid) return;
    lat = cyc - t0;
    got = {bus.rsp_rdata, bus.rsp_slverr,
           bus.rsp_timeout, bus.rsp_count};
    for (int h = 0; h < hold; h++) begin
      if (!bus.rsp_valid || bus.cmd_ready ||
          {bus.rsp_rdata, bus.rsp_slverr,
           bus.rsp_timeout, bus.rsp_count} !== got)
        held_ok = 1'b0;
      @(negedge clk);
    end
    if (!bus.rsp_valid || bus.cmd_ready ||
        {bus.rsp_rdata, bus.rsp_slverr,
         bus.rsp_timeout, bus.rsp_count} !== got)
      held_ok = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    if (!bus.cmd_ready || bus.rsp_valid) rdy_ok = 1'b0;
    wait_n    = 0;
    err_at    = -1;
    never_rdy = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_write  = 1'b0;
    bus.cmd_nwords = '0;
    bus.cmd_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.psel, bus.penable, bus.rsp_valid,
         bus.paddr, bus.rsp_slverr, bus.rsp_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b psel=%b pen=%b rv=%b want 0",
               bus.cmd_ready, bus.psel, bus.penable, bus.rsp_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0 ||
        bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%b psel=%b rv=%b want 1/0/0",
               bus.cmd_ready, bus.psel, bus.rsp_valid);
    end
  endtask

  task automatic test_single_read();
    int   lat;
    rsp_t got;
    rsp_t exp;
    bit   h;
    bit   r;
    run_cmd(32'h10, 1'b0, 2'd1, '0, -1, 0, 1'b0, 0,
            lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL single_read_lat: got %0d want 3", lat);
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL single_read_rsp: got %h want %h", got, exp);
    end
    n_cmp++;
    if (apb_q.size() != 0) begin
      n_bad++;
      $display("FAIL single_read_xfers: got %0d left want 0",
               apb_q.size());
    end
  endtask

  task automatic test_burst_write();
    int   lat;
    rsp_t got;
    rsp_t exp;
    bit   h;
    bit   r;
    setups = 0;
    run_cmd(32'h100, 1'b1, 2'd3,
            {32'h3, 32'h2, 32'h1}, -1, 0, 1'b0, 0,
            lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 7) begin
      n_bad++;
      $display("FAIL burst_write_lat: got %0d want 7", lat);
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL burst_write_rsp: got %h want %h", got, exp);
    end
    n_cmp++;
    if (apb_q.size() != 0 || setups != 3) begin
      n_bad++;
      $display("FAIL burst_write_xfers: left %0d setups %0d want 0/3",
               apb_q.size(), setups);
    end
  endtask

  task automatic test_slverr();
    int   lat;
    rsp_t got;
    rsp_t exp;
    bit   h;
    bit   r;
    run_cmd(32'h100, 1'b0, 2'd3, '0, 1, 0, 1'b0, 0,
            lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL slverr_lat: got %0d want 5", lat);
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL slverr_rsp: got %h want %h", got, exp);
    end
    n_cmp++;
    if (apb_q.size() != 0) begin
      n_bad++;
      $display("FAIL slverr_xfers: got %0d left want 0", apb_q.size());
    end
  endtask

  task automatic test_bad_len();
    int   lat;
    rsp_t got;
    rsp_t exp;
    bit   h;
    bit   r;
    setups = 0;
    run_cmd(32'h80, 1'b0, 2'd0, '0, -1, 0, 1'b0, 0,
            lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL bad_len_lat: got %0d want 1", lat);
    end
    n_cmp++;
    if (got !== exp || setups != 0) begin
      n_bad++;
      $display("FAIL bad_len_rsp: got %h setups %0d want %h/0",
               got, setups, exp);
    end
  endtask

  task automatic test_wrap();
    int   lat;
    rsp_t got;
    rsp_t exp;
    bit   h;
    bit   r;
    run_cmd(32'hFFFF_FFFC, 1'b0, 2'd2, '0, -1, 0, 1'b0, 0,
            lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 5 || got !== exp) begin
      n_bad++;
      $display("FAIL wrap_rsp: lat %0d rsp %h want 5 %h",
               lat, got, exp);
    end
    n_cmp++;
    if (apb_q.size() != 0) begin
      n_bad++;
      $display("FAIL wrap_xfers: got %0d left want 0", apb_q.size());
    end
  endtask

  task automatic test_stall();
    int   lat;
    rsp_t got;
    rsp_t exp;
    bit   h;
    bit   r;
    run_cmd(32'h200, 1'b1, 2'd1, {64'h0, 32'hCAFE_F00D},
            -1, 5, 1'b0, 4, lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL stall_lat: got %0d want 8", lat);
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL stall_rsp: got %h want %h", got, exp);
    end
    n_cmp++;
    if (h !== 1'b1 || r !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_hold: held %b ready %b want 1/1", h, r);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    rsp_t got;
    rsp_t exp;
    bit   h;
    bit   r;
    run_cmd(32'h40, 1'b0, 2'd2, '0, -1, 0, 1'b0, 0,
            lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 5 || got !== exp) begin
      n_bad++;
      $display("FAIL b2b_first: lat %0d rsp %h want 5 %h",
               lat, got, exp);
    end
    run_cmd(32'h48, 1'b1, 2'd1, {64'h0, 32'h1234_5678},
            -1, 0, 1'b0, 0, lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 3 || got !== exp || apb_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_second: lat %0d rsp %h want 3 %h",
               lat, got, exp);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    bit seen;
    apb_q.delete();
    wait_n = 10;
    @(negedge clk);
    bus.rsp_ready  = 1'b1;
    bus.cmd_addr   = 32'h300;
    bus.cmd_write  = 1'b0;
    bus.cmd_nwords = 2'd1;
    bus.cmd_valid  = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!(bus.psel && bus.penable) && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_abort: psel %b pen %b want 0/0",
               bus.psel, bus.penable);
    end
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.psel) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: activity %b rdy %b want 0/1",
               seen, bus.cmd_ready);
    end
    wait_n = 0;
  endtask

`ifdef APB_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    int   lat;
    rsp_t got;
    rsp_t exp;
    bit   h;
    bit   r;
    run_cmd(32'h400, 1'b0, 2'd1, '0, -1, 0, 1'b1, 0,
            lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 18 || got !== exp) begin
      n_bad++;
      $display("FAIL timeout_expire: lat %0d rsp %h want 18 %h",
               lat, got, exp);
    end
    run_cmd(32'h404, 1'b0, 2'd1, '0, -1, 15, 1'b0, 0,
            lat, got, h, r);
    exp = rsp_q.pop_front();
    n_cmp++;
    if (lat !== 18 || got !== exp) begin
      n_bad++;
      $display("FAIL timeout_last_ready: lat %0d rsp %h want 18 %h",
               lat, got, exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_burst_write();
    test_slverr();
    test_bad_len();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_INITIATOR_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
